// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply (shift-add) and divide/remainder (restoring), one bit per cycle.
module alu_mc #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] read_data,
    output logic [WIDTH-1:0] Z,
    output logic             done,
    output logic             zero,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [SHW-1:0]     r_step;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;

    logic [WIDTH-1:0]   r_z;
    logic               r_done;
    logic               r_zero;
    logic               r_dbz;

    logic               w_accept;
    logic               w_isMulti;
    logic [WIDTH-1:0]   w_single;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_remDiff;
    logic               w_remGeq;
    logic [WIDTH-1:0]   w_multiResult;
    logic               w_lastStep;

    assign in_ready    = (r_state == S_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_lastStep  = (r_step == SHW'(WIDTH - 1));

    assign Z           = r_z;
    assign done        = r_done;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;

    always_comb begin
        w_single  = '0;
        w_isMulti = 1'b0;
        case (opcode)
            4'b0000: w_single = X + Y;
            4'b0001: w_single = X - Y;
            4'b0010: w_single = X & Y;
            4'b0011: w_single = X | Y;
            4'b0100: w_single = X ^ Y;
            4'b0101: w_single = X >> Y[SHW-1:0];
            4'b0110: w_single = X << Y[SHW-1:0];
            4'b0111: w_single = {{(WIDTH-1){1'b0}}, (X >= Y)};
            4'b1100: w_single = read_data;
            4'b1101: w_single = Y;
            OP_MUL, OP_DIVU, OP_REMU: w_isMulti = 1'b1;
            default: w_single = '0;
        endcase
    end

    // Shift-add: upper half accumulates, multiplier drains out of the low half.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_x : {WIDTH{1'b0}})};
    assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

    // Partial remainder is WIDTH+1 bits; the top bit of the difference is the borrow.
    assign w_remShift = {r_rem, r_quo[WIDTH-1]};
    assign w_remDiff  = w_remShift - {1'b0, r_y};
    assign w_remGeq   = ~w_remDiff[WIDTH];

    always_comb begin
        case (r_op)
            OP_MUL:  w_multiResult = r_acc[WIDTH-1:0];
            OP_DIVU: w_multiResult = r_quo;
            default: w_multiResult = r_rem;
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && opcode == OP_MUL) begin
                    w_stateNext = S_MUL;
                end else if (w_accept && (opcode == OP_DIVU || opcode == OP_REMU)) begin
                    w_stateNext = S_DIV;
                end
            end
            S_MUL:   if (w_lastStep) w_stateNext = S_DONE;
            S_DIV:   if (w_lastStep) w_stateNext = S_DONE;
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op   <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_step <= '0;
            r_acc  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_z    <= '0;
            r_done <= 1'b0;
            r_zero <= 1'b1;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= opcode;
                        r_x    <= X;
                        r_y    <= Y;
                        r_step <= '0;
                        r_acc  <= {{WIDTH{1'b0}}, Y};
                        r_rem  <= '0;
                        r_quo  <= X;
                        if (!w_isMulti) begin
                            r_z    <= w_single;
                            r_zero <= (w_single == '0);
                            r_dbz  <= 1'b0;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc  <= w_mulNext;
                    r_step <= r_step + SHW'(1);
                end
                S_DIV: begin
                    r_rem  <= w_remGeq ? w_remDiff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
                    r_quo  <= {r_quo[WIDTH-2:0], w_remGeq};
                    r_step <= r_step + SHW'(1);
                end
                S_DONE: begin
                    r_z    <= w_multiResult;
                    r_zero <= (w_multiResult == '0);
                    r_dbz  <= (r_op != OP_MUL) && (r_y == '0);
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
